// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants for the 2-read/1-write register file.
package rf_pkg;

  // Default register width and address width (NREG = 2**ADDR_W).
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;

  // Index of the register that can be hardwired to zero.
  localparam int RF_ZERO_IDX = 0;

endpackage : rf_pkg

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the register file: one write port and two read ports.
interface reg_file_2r1w_if
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  // The datapath side drives writes and read addresses.
  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  // The register file consumes them and returns combinational read data.
  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );

endinterface : reg_file_2r1w_if

// File: rtl/reg_file_2r1w_rf_cell.sv
// One storage register: loads d_i when en_i is high, cleared asynchronously by reset.
module rf_cell
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Hold the current value unless this cell is the write target.
  always_comb begin
    data_d = en_i ? d_i : data_q;
  end

  // Storage with asynchronous clear so reads return 0 as soon as reset rises.
  // NOTE: every storage cell is reset, which costs a clear pin per flop; it is
  // needed here because unwritten registers must never read as X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      // NOTE: non-blocking so all flops update together at the edge.
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : rf_cell

// File: rtl/reg_file_2r1w.sv
// General-purpose register file: NREG x DATA_W, one synchronous write port,
// two combinational read ports, optional hardwired-zero r0 and write bypass.
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_file_2r1w_if.slave        rf
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_IDX);

  logic [NREG-1:0]   wen;
  logic              write_live;
  logic              byp1;
  logic              byp2;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Write decoder: one-hot cell enable; writes to a hardwired r0 are dropped here.
  always_comb begin
    // NOTE: default first so every path assigns wen and no latch is inferred.
    wen = '0;
    if (rf.we && !(ZERO_REG && (rf.waddr == ZERO_ADDR))) begin
      wen[rf.waddr] = 1'b1;
    end
  end

  // A write is effective exactly when some cell is enabled.
  assign write_live = |wen;

  // Storage array; a hardwired r0 has no cell at all.
  for (genvar i = 0; i < NREG; i++) begin : g_cell
    if (ZERO_REG && (i == RF_ZERO_IDX)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_reg
      rf_cell #(.DATA_W(DATA_W)) u_cell (
        .clk   (clk),
        .reset (reset),
        .en_i  (wen[i]),
        .d_i   (rf.wdata),
        .q_o   (regs[i])
      );
    end
  end

  // Bypass hit per port; reset suppresses forwarding so reads stay 0.
  always_comb begin
    byp1 = BYPASS && !reset && write_live && (rf.raddr1 == rf.waddr);
    byp2 = BYPASS && !reset && write_live && (rf.raddr2 == rf.waddr);
  end

  // Read muxes with same-cycle forwarding of the incoming write data.
  always_comb begin
    rd1 = regs[rf.raddr1];
    rd2 = regs[rf.raddr2];
    if (byp1) rd1 = rf.wdata;
    if (byp2) rd2 = rf.wdata;
  end

  assign rf.rdata1 = rd1;
  assign rf.rdata2 = rd2;

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w. Two instances run side by side on the same
// stimulus: dut_a (ZERO_REG=1, BYPASS=1) and dut_b (ZERO_REG=0, BYPASS=0).
module tb_reg_file_2r1w;
  import rf_pkg::*;

  localparam int DW   = DATA_W_DEF;
  localparam int AW   = ADDR_W_DEF;
  localparam int NREG = 2 ** AW;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] exp1_a;
    logic [DW-1:0] exp2_a;
    logic [DW-1:0] exp1_b;
    logic [DW-1:0] exp2_b;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;

  int checks = 0;
  int errors = 0;

  vec_t vecs [10];

  reg_file_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
  reg_file_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

  assign if_a.we     = we;
  assign if_a.waddr  = waddr;
  assign if_a.wdata  = wdata;
  assign if_a.raddr1 = raddr1;
  assign if_a.raddr2 = raddr2;
  assign if_b.we     = we;
  assign if_b.waddr  = waddr;
  assign if_b.wdata  = wdata;
  assign if_b.raddr1 = raddr1;
  assign if_b.raddr2 = raddr2;

  reg_file_2r1w #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .rf    (if_a.slave)
  );

  reg_file_2r1w #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .rf    (if_b.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one set of inputs at the falling edge, settle, leave 40 units to the rising edge.
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    @(negedge clk);
    we     = w;
    waddr  = wa;
    wdata  = wd;
    raddr1 = a1;
    raddr2 = a2;
    #10;
  endtask

  task automatic check_all(input string name, input logic [DW-1:0] e1a, input logic [DW-1:0] e2a,
                           input logic [DW-1:0] e1b, input logic [DW-1:0] e2b);
    check({name, " a.rd1"}, if_a.rdata1, e1a);
    check({name, " a.rd2"}, if_a.rdata2, e2a);
    check({name, " b.rd1"}, if_b.rdata1, e1b);
    check({name, " b.rd2"}, if_b.rdata2, e2b);
  endtask

  initial begin
    // Each vector is checked before its write edge; expectations hand-derived.
    vecs[0] = '{1'b1, 5'd5, 32'hAFAFAFAF, 5'd5, 5'd0, 32'hAFAFAFAF, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hAFAFAFAF, 32'hAFAFAFAF, 32'hAFAFAFAF, 32'hAFAFAFAF};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 5'd7, 32'h12345678, 5'd5, 5'd7, 32'hAFAFAFAF, 32'h12345678, 32'hAFAFAFAF, 32'h0};
    vecs[5] = '{1'b1, 5'd3, 32'h00000001, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[6] = '{1'b1, 5'd4, 32'h00000002, 5'd3, 5'd4, 32'h00000001, 32'h00000002, 32'h00000001, 32'h0};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd4, 32'h00000001, 32'h00000002, 32'h00000001, 32'h00000002};
    vecs[8] = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd3, 32'hDEADBEEF, 32'h00000001, 32'h12345678, 32'h00000001};
    vecs[9] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF};

    // Reset asserted from t0 with a write to r5 pending across a clock edge.
    reset  = 1'b1;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr1 = '0;
    raddr2 = '0;
    step(1'b1, 5'd5, 32'hAFAFAFAF, 5'd5, 5'd5);
    check_all("rst write cycle", 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    we    = 1'b0;
    #10;
    check_all("rst r5 dropped", 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < NREG; i++) begin
      raddr1 = AW'(i);
      raddr2 = AW'(NREG - 1 - i);
      #1;
      check($sformatf("post-rst r%0d a", i), if_a.rdata1, 32'h0);
      check($sformatf("post-rst r%0d b", i), if_b.rdata2, 32'h0);
    end

    // Table of single-cycle vectors.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr1, vecs[i].raddr2);
      check_all($sformatf("vec%0d", i), vecs[i].exp1_a, vecs[i].exp2_a, vecs[i].exp1_b, vecs[i].exp2_b);
    end

    // Old value before the edge and new value after it on the non-bypass instance.
    step(1'b1, 5'd9, 32'hCAFE0009, 5'd9, 5'd9);
    check("byp0 r9 before edge", if_b.rdata1, 32'h0);
    check("byp1 r9 before edge", if_a.rdata2, 32'hCAFE0009);
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    check_all("r9 after edge", 32'hCAFE0009, 32'hCAFE0009, 32'hCAFE0009, 32'hCAFE0009);

    // Populate r1..r31, then confirm a few values.
    for (int i = 1; i < NREG; i++) begin
      step(1'b1, AW'(i), 32'h10000000 + DW'(i), 5'd0, 5'd0);
    end
    step(1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
    check_all("populated", 32'h1000001F, 32'h10000001, 32'h1000001F, 32'h10000001);

    // Reset raised mid-cycle: every read goes to 0 well before the next rising edge.
    @(negedge clk);
    #5;
    reset = 1'b1;
    we    = 1'b1;
    waddr = 5'd12;
    wdata = 32'h55555555;
    for (int i = 0; i < NREG; i++) begin
      raddr1 = AW'(i);
      raddr2 = AW'(NREG - 1 - i);
      #1;
      check_all($sformatf("midrst r%0d", i), 32'h0, 32'h0, 32'h0, 32'h0);
    end
    @(negedge clk);
    reset  = 1'b0;
    we     = 1'b0;
    raddr1 = 5'd12;
    raddr2 = 5'd31;
    #10;
    check_all("after midrst", 32'h0, 32'h0, 32'h0, 32'h0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_2r1w
